uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- UART serial receiver; consumes the 16x-oversample `baud_tick` strobe produced by the baud-rate generator.
- Deserialises 8N1-style frames from the `rx` pin, LSB first.
- Presents each received byte on a valid/ready handshake toward the IoT packet logic.
- Reports framing errors and overrun errors as single-cycle pulses.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 16, `baud_tick` strobes per bit period; must be even and at least 4.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clock strobe at OVERSAMPLE x baud rate.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last accepted byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_error  output  1  one-clock pulse: stop bit sampled low.
- overrun_error  output  1  one-clock pulse: completed frame dropped because rx_valid was still high.

Behaviour:
- Single clock domain (`clock`); reset is synchronous and active-high (`reset`).
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_error = 0, overrun_error = 0.
  - State IDLE; tick counter = 0; bit index = 0.
  - Synchroniser flops preset to 1.
- Reset asserted mid-frame aborts the frame with no error pulse.
- Input conditioning: `rx` passes through a 2-flop synchroniser; all decisions use the synchronised value `rxs`.
- Tick counter:
  - Width clog2(OVERSAMPLE).
  - Advances only on clocks with baud_tick = 1.
  - Cleared on every state entry.
- FSM, IDLE:
  - Evaluated every clock, not only on ticks.
  - rxs = 0 -> START, counter = 0.
- FSM, START:
  - On the tick where counter == OVERSAMPLE/2-1 (7 by default), sample rxs (mid-start-bit).
  - rxs = 0 -> DATA, counter = 0, bit index = 0.
  - rxs = 1 -> false start, return to IDLE; no error pulse.
- FSM, DATA:
  - On the tick where counter == OVERSAMPLE-1, sample rxs.
  - Shift the sample into the MSB of a DATA_BITS shift register (right shift) so the first bit lands at bit 0 after DATA_BITS shifts.
  - Increment the bit index; after the DATA_BITS-th sample -> STOP (or PARITY, see Optional Feature).
- FSM, STOP:
  - On the tick where counter == OVERSAMPLE-1, sample rxs.
  - rxs = 1: frame good.
  - rxs = 0: frame_error pulses on the next clock; data is discarded.
  - Either case -> IDLE.
  - A low line after a frame error is treated as a new start edge in IDLE.
- Completion latency: the good-frame decision is made on the stop-sample tick clock; rx_data/rx_valid update on the following clock edge.
- Handshake:
  - rx_valid stays high until a clock with rx_ready = 1; rx_valid then clears on the next edge.
  - rx_data is stable while rx_valid = 1.
  - rx_ready while rx_valid = 0 has no effect.
- Overrun:
  - A good frame completes while rx_valid = 1 and rx_ready = 0 -> overrun_error pulses one clock.
  - The new byte is dropped; old rx_data and rx_valid are kept.
- Simultaneous completion and acceptance:
  - Good frame completes on the same clock that rx_valid && rx_ready = 1.
  - The old byte is consumed, the new byte is loaded, and rx_valid stays 1.
  - No overrun is reported.
- baud_tick held continuously high (tick every clock) is legal; timing then counts clocks.
- No error output is sticky; error pulses are never asserted by reset.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even) and a PARITY state between DATA and STOP.
  - The parity bit is sampled at counter == OVERSAMPLE-1.
  - Adds output parity_error (1 bit, reset 0). It pulses for one clock after STOP when the received parity mismatches the XOR of the data bits (inverted for odd).
  - A byte with a parity error is discarded like a framing error.
  - If both errors occur, both pulse on the same clock.
- Undefined:
  - No PARITY state and no parity_error port.
  - Frame is start + DATA_BITS + stop.

Test Plan:
1. Reset, then idle rx = 1 for 1000 clocks, baud_tick every 4 clocks -> rx_valid, frame_error and overrun_error all stay 0; state IDLE.
2. Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 ticks per bit, rx_ready = 1 -> rx_data = 0xA5 and rx_valid high for exactly one clock, 1 clock after the stop-sample tick.
3. Glitch: rx low for 5 ticks then high -> no rx_valid; a following valid 0x3C frame is received correctly.
4. Send 0x55 with stop bit = 0 -> frame_error single pulse, rx_valid stays 0; a following 0x0F frame with no idle gap is received correctly.
5. rx_ready = 0; send 0x11 then 0x22 -> rx_data = 0x11 held, overrun_error pulses at the end of 0x22. Raise rx_ready -> rx_valid drops the next clock.
6. Assert reset mid-data-bit of frame 0xFF -> all outputs 0 the next clock. A subsequent 0x81 frame is received correctly.
   With UART_RX_PARITY_EN: 0x07 sent with even-parity bit 0 -> parity_error pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx_oversampled_if.sv
// rtl/uart_rx_oversampled_if.sv - received-byte valid/ready handshake between UART receiver and consumer
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver delivering bytes on a valid/ready handshake
// Defining UART_RX_PARITY_EN adds a parity bit stage and the parity_error output.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic                  rx,
    uart_rx_oversampled_if.master rx_bus,
    output logic                  frame_error,
    output logic                  overrun_error
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_error
`endif
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic                 rx_meta;
    logic                 rxs;
    logic [2:0]           state;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    logic mid_tick;
    logic end_tick;
    logic stop_sample;
    logic frame_ok;
    logic accept;
    logic hold_old;

    assign mid_tick    = baud_tick && (tick_cnt == HALF_LAST);
    assign end_tick    = baud_tick && (tick_cnt == FULL_LAST);
    assign stop_sample = (state == ST_STOP) && end_tick;

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic parity_ok;
    assign parity_ok = (parity_bit == ((^shift_reg) ^ PARITY_ODD));
    assign frame_ok  = stop_sample && rxs && parity_ok;
`else
    assign frame_ok  = stop_sample && rxs;
`endif

    assign accept   = rx_bus.rx_valid && rx_bus.rx_ready;
    // An unconsumed byte that is not being taken this clock wins over a new frame.
    assign hold_old = rx_bus.rx_valid && !rx_bus.rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta          <= 1'b1;
            rxs              <= 1'b1;
            state            <= ST_IDLE;
            tick_cnt         <= '0;
            bit_idx          <= '0;
            shift_reg        <= '0;
            rx_bus.rx_data   <= '0;
            rx_bus.rx_valid  <= 1'b0;
            frame_error      <= 1'b0;
            overrun_error    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit       <= 1'b0;
            parity_error     <= 1'b0;
`endif
        end else begin
            rx_meta       <= rx;
            rxs           <= rx_meta;
            frame_error   <= stop_sample && !rxs;
            overrun_error <= frame_ok && hold_old;
`ifdef UART_RX_PARITY_EN
            parity_error  <= stop_sample && !parity_ok;
`endif

            if (frame_ok && !hold_old) begin
                rx_bus.rx_data  <= shift_reg;
                rx_bus.rx_valid <= 1'b1;
            end else if (accept) begin
                rx_bus.rx_valid <= 1'b0;
            end

            if (baud_tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    if (!rxs) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (mid_tick) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (end_tick) begin
                        tick_cnt  <= '0;
                        shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (end_tick) begin
                        tick_cnt   <= '0;
                        parity_bit <= rxs;
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (end_tick) begin
                        tick_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;
    logic clock = 1'b0;
    logic reset;
    logic baud_tick;
    logic rx;
    logic frame_error;
    logic overrun_error;
`ifdef UART_RX_PARITY_EN
    logic parity_error;
    bit   par_flip;
    int   pecount;
    // start-edge to rx_valid latency in clocks, for 4-clock and 1-clock tick spacing
    localparam int LAT4 = 674;
    localparam int LAT1 = 171;
`else
    localparam int LAT4 = 610;
    localparam int LAT1 = 155;
`endif

    uart_rx_oversampled_if #(.DATA_BITS(8)) rx_bus ();

    uart_rx_oversampled dut (
        .clock         (clock),
        .reset         (reset),
        .baud_tick     (baud_tick),
        .rx            (rx),
        .rx_bus        (rx_bus),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (parity_error)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int div   = 4;
    int phase = 0;
    int vcount, fecount, oecount, first_valid;
    int pulse_cyc = -1;
    int fs;
    logic [7:0] last_data;

    task automatic clear_mon();
        vcount = 0; fecount = 0; oecount = 0; first_valid = -1;
`ifdef UART_RX_PARITY_EN
        pecount = 0;
`endif
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        if (rx_bus.rx_valid) begin
            vcount++;
            last_data = rx_bus.rx_data;
            if (first_valid < 0) first_valid = cyc;
        end
        if (frame_error) fecount++;
        if (overrun_error) oecount++;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pecount++;
`endif
        baud_tick = (phase == 0);
        phase = (phase + 1) % div;
        if (pulse_cyc >= 0 && cyc == pulse_cyc) begin
            rx_bus.rx_ready = 1'b1;
        end else if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) begin
            rx_bus.rx_ready = 1'b0;
            pulse_cyc = -1;
        end
    endtask

    task automatic run_ticks(input int n);
        repeat (n * div) step();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        run_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_bit);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; baud_tick = 1'b0; rx_bus.rx_ready = 1'b0;
        div = 4; phase = 0;
        repeat (4) step();
        reset = 1'b0;
        total++; if (rx_bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", rx_bus.rx_valid); end
        total++; if (rx_bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 00", rx_bus.rx_data); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %0b want 0", frame_error); end
        total++; if (overrun_error !== 1'b0) begin bad++; $display("FAIL reset_oerr: got %0b want 0", overrun_error); end
    endtask

    task automatic test_idle();
        clear_mon();
        run_ticks(250);
        total++; if (vcount !== 0) begin bad++; $display("FAIL idle_valid: got %0d want 0", vcount); end
        total++; if (fecount !== 0) begin bad++; $display("FAIL idle_ferr: got %0d want 0", fecount); end
        total++; if (oecount !== 0) begin bad++; $display("FAIL idle_oerr: got %0d want 0", oecount); end
        total++; if (dut.state !== 3'd0) begin bad++; $display("FAIL idle_state: got %0d want 0", dut.state); end
    endtask

    task automatic test_basic();
        rx_bus.rx_ready = 1'b1;
        clear_mon();
        fs = cyc;
        send_frame(8'hA5, 1'b1);
        total++; if (last_data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %0h want a5", last_data); end
        total++; if (vcount !== 1) begin bad++; $display("FAIL basic_valid_cycles: got %0d want 1", vcount); end
        total++; if (first_valid - fs !== LAT4) begin bad++; $display("FAIL basic_latency: got %0d want %0d", first_valid - fs, LAT4); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        run_ticks(5);
        rx = 1'b1;
        run_ticks(20);
        total++; if (vcount !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", vcount); end
        total++; if (fecount !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", fecount); end
        clear_mon();
        send_frame(8'h3C, 1'b1);
        total++; if (last_data !== 8'h3C) begin bad++; $display("FAIL glitch_next_data: got %0h want 3c", last_data); end
        total++; if (vcount !== 1) begin bad++; $display("FAIL glitch_next_valid: got %0d want 1", vcount); end
    endtask

    task automatic test_frame_error();
        div = 1; phase = 0;
        run_ticks(8);
        clear_mon();
        send_frame(8'h55, 1'b0);
        total++; if (fecount !== 1) begin bad++; $display("FAIL ferr_pulse: got %0d want 1", fecount); end
        total++; if (vcount !== 0) begin bad++; $display("FAIL ferr_valid: got %0d want 0", vcount); end
        clear_mon();
        fs = cyc;
        send_frame(8'h0F, 1'b1);
        total++; if (last_data !== 8'h0F) begin bad++; $display("FAIL ferr_next_data: got %0h want 0f", last_data); end
        total++; if (vcount !== 1) begin bad++; $display("FAIL ferr_next_valid: got %0d want 1", vcount); end
        total++; if (fecount !== 0) begin bad++; $display("FAIL ferr_next_ferr: got %0d want 0", fecount); end
    endtask

    task automatic test_overrun();
        rx_bus.rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        total++; if (rx_bus.rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %0b want 1", rx_bus.rx_valid); end
        total++; if (rx_bus.rx_data !== 8'h11) begin bad++; $display("FAIL ovr_data: got %0h want 11", rx_bus.rx_data); end
        total++; if (oecount !== 1) begin bad++; $display("FAIL ovr_pulse: got %0d want 1", oecount); end
        rx_bus.rx_ready = 1'b1;
        step();
        total++; if (rx_bus.rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_release: got %0b want 0", rx_bus.rx_valid); end
    endtask

    task automatic test_back_to_back();
        rx_bus.rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h5A, 1'b1);
        fs = cyc;
        pulse_cyc = fs + LAT1 - 1;
        send_frame(8'hC3, 1'b1);
        total++; if (rx_bus.rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %0b want 1", rx_bus.rx_valid); end
        total++; if (rx_bus.rx_data !== 8'hC3) begin bad++; $display("FAIL b2b_data: got %0h want c3", rx_bus.rx_data); end
        total++; if (oecount !== 0) begin bad++; $display("FAIL b2b_overrun: got %0d want 0", oecount); end
        rx_bus.rx_ready = 1'b1;
        step();
        total++; if (rx_bus.rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_release: got %0b want 0", rx_bus.rx_valid); end
    endtask

    task automatic test_reset_mid();
        rx_bus.rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        rx = 1'b0;
        run_ticks(16);
        rx = 1'b1;
        run_ticks(8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (rx_bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %0b want 0", rx_bus.rx_valid); end
        total++; if (rx_bus.rx_data !== 8'h00) begin bad++; $display("FAIL rmid_data: got %0h want 00", rx_bus.rx_data); end
        clear_mon();
        run_ticks(136);
        total++; if (vcount !== 0) begin bad++; $display("FAIL rmid_after_valid: got %0d want 0", vcount); end
        total++; if (fecount !== 0) begin bad++; $display("FAIL rmid_after_ferr: got %0d want 0", fecount); end
        rx_bus.rx_ready = 1'b1;
        clear_mon();
        send_frame(8'h81, 1'b1);
        total++; if (last_data !== 8'h81) begin bad++; $display("FAIL rmid_next_data: got %0h want 81", last_data); end
        total++; if (vcount !== 1) begin bad++; $display("FAIL rmid_next_valid: got %0d want 1", vcount); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        rx_bus.rx_ready = 1'b1;
        clear_mon();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        total++; if (pecount !== 1) begin bad++; $display("FAIL par_pulse: got %0d want 1", pecount); end
        total++; if (vcount !== 0) begin bad++; $display("FAIL par_valid: got %0d want 0", vcount); end
        total++; if (fecount !== 0) begin bad++; $display("FAIL par_ferr: got %0d want 0", fecount); end
    endtask
`endif

    initial begin
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        test_reset();
        test_idle();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
